// File: rtl/cnn_pkg.sv
// Shared definitions for the conv1->conv2 feature-map reader.
// Holds the default map geometry, the channel count and the reader state type.
package cnn_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned FMAP_W = 26;
   localparam int unsigned FMAP_H = 26;
   localparam int unsigned K      = 3;
   localparam int unsigned OW     = FMAP_W - K + 1;
   localparam int unsigned OH     = FMAP_H - K + 1;
   localparam int unsigned NCH    = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } rd_state_t;

endpackage

// File: rtl/cnn2_win_addr_gen.sv
// Window address generator for the conv2 reader.
// Walks kc -> kr -> c -> r in raster order and produces the buffer address
// (r+kr)*FMAP_W + (c+kc) without a multiplier.
// Ports:
//   clk, global_rst : clock, synchronous active-high reset
//   clear           : zero all counters (frame start)
//   issue           : advance to the next kernel position
//   addr            : address of the current position
//   kidx            : kernel position kr*K+kc of the current position
//   last_issue      : current position is the final one of the frame
module cnn2_win_addr_gen #(
   parameter int unsigned FMAP_W = 26,
   parameter int unsigned FMAP_H = 26,
   parameter int unsigned K      = 3,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              global_rst,
   input  logic              clear,
   input  logic              issue,
   output logic [ADDR_W-1:0] addr,
   output logic [3:0]        kidx,
   output logic              last_issue
);
   import cnn_pkg::*;

   localparam int unsigned OW = FMAP_W - K + 1;
   localparam int unsigned OH = FMAP_H - K + 1;
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FMAP_W);

   logic [ADDR_W-1:0] r, c;
   logic [3:0]        kr, kc;
   // rbase = r*FMAP_W (window origin row), wbase = (r+kr)*FMAP_W (current row)
   logic [ADDR_W-1:0] rbase, wbase;
   logic              kc_w, kr_w, c_w, r_w;

   always_comb begin
      kc_w       = (kc == 4'(K - 1));
      kr_w       = (kr == 4'(K - 1));
      c_w        = (c == ADDR_W'(OW - 1));
      r_w        = (r == ADDR_W'(OH - 1));
      last_issue = kc_w && kr_w && c_w && r_w;
      addr       = wbase + c + ADDR_W'(kc);
   end

   always_ff @(posedge clk) begin
      if (global_rst || clear) begin
         r     <= '0;
         c     <= '0;
         kr    <= '0;
         kc    <= '0;
         kidx  <= '0;
         rbase <= '0;
         wbase <= '0;
      end else if (issue) begin
         if (!kc_w) begin
            kc   <= kc + 4'd1;
            kidx <= kidx + 4'd1;
         end else begin
            kc <= '0;
            if (!kr_w) begin
               kr    <= kr + 4'd1;
               kidx  <= kidx + 4'd1;
               wbase <= wbase + ROW_STEP;
            end else begin
               kr   <= '0;
               kidx <= '0;
               if (!c_w) begin
                  // next window on the same output row starts back at row r
                  c     <= c + ADDR_W'(1);
                  wbase <= rbase;
               end else begin
                  c <= '0;
                  if (!r_w) begin
                     r     <= r + ADDR_W'(1);
                     rbase <= rbase + ROW_STEP;
                     wbase <= rbase + ROW_STEP;
                  end else begin
                     r     <= '0;
                     rbase <= '0;
                     wbase <= '0;
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/cnn2_window_reader.sv
// Read-side sequencer for the 4-channel conv1->conv2 feature-map buffer.
// Walks every KxK window in raster order, drives the buffer read port and
// streams the returned pixels with kernel-position tags over valid/ready.
// Ports:
//   clk, global_rst           : clock, synchronous active-high reset
//   start / busy / done       : frame control and status
//   read_start / readaddr     : buffer read enable and address (1-cycle latency)
//   data_inm1..4              : buffer outputs, held while read_start is low
//   data_out1..4              : window pixels, passed through
//   out_valid / out_ready     : beat handshake
//   k_idx, win_first, win_last: kernel-position tags of the current beat
module cnn2_window_reader #(
   parameter int unsigned FMAP_W = 26,
   parameter int unsigned FMAP_H = 26,
   parameter int unsigned K      = 3,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              global_rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              read_start,
   output logic [ADDR_W-1:0] readaddr,
   input  logic [DATA_W-1:0] data_inm1,
   input  logic [DATA_W-1:0] data_inm2,
   input  logic [DATA_W-1:0] data_inm3,
   input  logic [DATA_W-1:0] data_inm4,
   output logic [DATA_W-1:0] data_out1,
   output logic [DATA_W-1:0] data_out2,
   output logic [DATA_W-1:0] data_out3,
   output logic [DATA_W-1:0] data_out4,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        k_idx,
   output logic              win_first,
   output logic              win_last
);
   import cnn_pkg::*;

   if (longint'(FMAP_W) * longint'(FMAP_H) > (longint'(1) << ADDR_W)) begin : g_addr_chk
      $error("feature map does not fit in ADDR_W address bits");
   end
   if (K * K > 16) begin : g_kidx_chk
      $error("K*K kernel positions do not fit in the 4-bit k_idx tag");
   end

   rd_state_t   state, state_nxt;
   logic        issue, clear, done_nxt, last_issue;
   logic [3:0]  kidx;

   cnn2_win_addr_gen #(
      .FMAP_W(FMAP_W),
      .FMAP_H(FMAP_H),
      .K     (K),
      .ADDR_W(ADDR_W)
   ) u_addr (
      .clk       (clk),
      .global_rst(global_rst),
      .clear     (clear),
      .issue     (issue),
      .addr      (readaddr),
      .kidx      (kidx),
      .last_issue(last_issue)
   );

   always_ff @(posedge clk) begin
      if (global_rst) state <= IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (issue && last_issue) state_nxt = DRAIN;
         DRAIN:   if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      // a new read may go out when the output slot is empty or being drained
      issue      = (state == RUN) && (!out_valid || out_ready);
      read_start = issue;
      busy       = (state != IDLE);
      clear      = (state == IDLE) && start;
      done_nxt   = (state == DRAIN) && out_valid && out_ready;
   end

   always_ff @(posedge clk) begin
      if (global_rst) begin
         done      <= 1'b0;
         out_valid <= 1'b0;
         k_idx     <= '0;
         win_first <= 1'b0;
         win_last  <= 1'b0;
      end else begin
         done <= done_nxt;
         if (issue) begin
            out_valid <= 1'b1;
            k_idx     <= kidx;
            win_first <= (kidx == 4'd0);
            win_last  <= (kidx == 4'(K * K - 1));
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // buffer holds its outputs while read_start is low, so stalls need no skid
   assign data_out1 = data_inm1;
   assign data_out2 = data_inm2;
   assign data_out3 = data_inm3;
   assign data_out4 = data_inm4;

endmodule

// File: tb/tb_cnn2_window_reader.sv
module tb_cnn2_window_reader;

   localparam int FW = 5;
   localparam int FH = 5;
   localparam int KK = 3;
   localparam int OWW = FW - KK + 1;
   localparam int OHH = FH - KK + 1;
   localparam int NB = OWW * OHH * KK * KK;

   logic        clk = 1'b0;
   logic        global_rst, start, out_ready;
   logic        busy, done, read_start, out_valid, win_first, win_last;
   logic [15:0] readaddr;
   logic [7:0]  data_inm1, data_inm2, data_inm3, data_inm4;
   logic [7:0]  data_out1, data_out2, data_out3, data_out4;
   logic [3:0]  k_idx;

   always #5 clk = ~clk;

   cnn2_window_reader #(
      .FMAP_W(FW),
      .FMAP_H(FH),
      .K     (KK),
      .ADDR_W(16),
      .DATA_W(8)
   ) dut (
      .clk       (clk),
      .global_rst(global_rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .read_start(read_start),
      .readaddr  (readaddr),
      .data_inm1 (data_inm1),
      .data_inm2 (data_inm2),
      .data_inm3 (data_inm3),
      .data_inm4 (data_inm4),
      .data_out1 (data_out1),
      .data_out2 (data_out2),
      .data_out3 (data_out3),
      .data_out4 (data_out4),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .k_idx     (k_idx),
      .win_first (win_first),
      .win_last  (win_last)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // pixel stored for channel ch (0..3) at address a
   function automatic logic [7:0] pix(input int ch, input int a);
      if (a < 0 || a >= FW * FH) return 8'hEE;
      return 8'((ch << 6) | a);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // buffer model: one-cycle read latency, outputs held while read_start is low
   always @(posedge clk) begin
      if (read_start) begin
         data_inm1 <= pix(0, int'(readaddr));
         data_inm2 <= pix(1, int'(readaddr));
         data_inm3 <= pix(2, int'(readaddr));
         data_inm4 <= pix(3, int'(readaddr));
      end
   end

   // reference beat sequence built from the window walk definition
   int m_addr [NB];
   initial begin
      int i;
      i = 0;
      for (int r = 0; r < OHH; r++)
         for (int c = 0; c < OWW; c++)
            for (int kr = 0; kr < KK; kr++)
               for (int kc = 0; kc < KK; kc++) begin
                  m_addr[i] = (r + kr) * FW + (c + kc);
                  i++;
               end
   end

   bit          chk_en = 1'b0;
   int          iss_cnt = 0, acc_cnt = 0;
   int          log_addr [NB];
   int          hs_cyc [NB];
   int          first_iss_cyc = 0, first_ov_cyc = 0;
   bit          ov_seen = 1'b0, exp_done = 1'b0, stall_prev = 1'b0;
   logic [15:0] prev_addr;
   logic [31:0] prev_data;

   always @(negedge clk) begin
      if (global_rst) begin
         iss_cnt = 0; acc_cnt = 0; exp_done = 1'b0; stall_prev = 1'b0; ov_seen = 1'b0;
      end else if (chk_en) begin
         chk("done", done, exp_done);
         exp_done = 1'b0;
         if (done) begin
            iss_cnt = 0; acc_cnt = 0; ov_seen = 1'b0;
         end
         if (read_start) begin
            if (iss_cnt >= NB) chk("issue_count", iss_cnt, NB - 1);
            else begin
               chk("readaddr", readaddr, m_addr[iss_cnt]);
               log_addr[iss_cnt] = int'(readaddr);
               if (iss_cnt == 0) first_iss_cyc = cyc;
               iss_cnt++;
            end
         end
         if (out_valid) begin
            if (acc_cnt >= NB) chk("beat_count", acc_cnt, NB - 1);
            else begin
               chk("data_out1", data_out1, pix(0, m_addr[acc_cnt]));
               chk("data_out2", data_out2, pix(1, m_addr[acc_cnt]));
               chk("data_out3", data_out3, pix(2, m_addr[acc_cnt]));
               chk("data_out4", data_out4, pix(3, m_addr[acc_cnt]));
               chk("k_idx", k_idx, acc_cnt % (KK * KK));
               chk("win_first", win_first, (acc_cnt % (KK * KK)) == 0);
               chk("win_last", win_last, (acc_cnt % (KK * KK)) == KK * KK - 1);
               if (!ov_seen) begin first_ov_cyc = cyc; ov_seen = 1'b1; end
               if (!out_ready) begin
                  chk("stall_read_start", read_start, 0);
                  if (stall_prev) begin
                     chk("stall_readaddr", readaddr, prev_addr);
                     chk("stall_data", {data_out1, data_out2, data_out3, data_out4}, prev_data);
                  end
               end
               stall_prev = !out_ready;
               prev_addr  = readaddr;
               prev_data  = {data_out1, data_out2, data_out3, data_out4};
               if (out_ready) begin
                  hs_cyc[acc_cnt] = cyc;
                  if (acc_cnt == NB - 1) exp_done = 1'b1;
                  acc_cnt++;
               end
            end
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_read_start"}, read_start, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_win_first"}, win_first, 0);
      chk({tag, "_win_last"}, win_last, 0);
      chk({tag, "_readaddr"}, readaddr, 0);
      chk({tag, "_k_idx"}, k_idx, 0);
   endtask

   task automatic check_frame(input int t_start, input int exp_span);
      int lit [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
      chk("frame_beats", acc_cnt, NB);
      chk("frame_issues", iss_cnt, NB);
      for (int i = 0; i < 9; i++) chk("first_window_addr", log_addr[i], lit[i]);
      chk("second_window_start", log_addr[9], 1);
      chk("last_addr", log_addr[NB - 1], 24);
      chk("beat_span", hs_cyc[NB - 1] - hs_cyc[0], exp_span);
      chk("first_read_latency", first_iss_cyc - t_start, 1);
      chk("first_valid_latency", first_ov_cyc - t_start, 2);
      chk("done_after_last_beat", cyc - hs_cyc[NB - 1], 1);
      chk("busy_in_done_cycle", busy, 0);
   endtask

   task automatic drive_frame(input int stall_beat, input int start_beat, input int rst_beat,
                              output bit got_done, output bit aborted);
      int stall_left;
      bit stall_used, start_used;
      stall_left = 0; stall_used = 1'b0; start_used = 1'b0;
      got_done = 1'b0; aborted = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int n = 0; n < 400 && !got_done && !aborted; n++) begin
         if (done) got_done = 1'b1;
         else if (rst_beat >= 0 && acc_cnt >= rst_beat) begin
            global_rst = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            global_rst = 1'b0;
            aborted = 1'b1;
         end else begin
            start = 1'b0;
            if (stall_left > 0) begin
               stall_left--;
               if (stall_left == 0) out_ready = 1'b1;
            end else if (!stall_used && acc_cnt == stall_beat) begin
               out_ready  = 1'b0;
               stall_left = 3;
               stall_used = 1'b1;
            end
            if (!start_used && acc_cnt == start_beat) begin
               start      = 1'b1;
               start_used = 1'b1;
            end
            @(posedge clk); #1;
         end
      end
      if (!got_done && !aborted) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int t_a, t_b, t_c, t_d;
      bit got, ab;
      global_rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      data_inm1 = '0; data_inm2 = '0; data_inm3 = '0; data_inm4 = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      global_rst = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;

      // unstalled frame
      start = 1'b1; t_a = cyc;
      drive_frame(-1, -1, -1, got, ab);
      if (got) check_frame(t_a, NB - 1);

      // 3-cycle stall at beat 20, ignored start at beat 40, chained start on done
      @(posedge clk); #1;
      start = 1'b1; t_b = cyc;
      drive_frame(20, 40, -1, got, ab);
      if (got) check_frame(t_b, NB - 1 + 3);
      start = 1'b1; t_c = cyc;

      // chained frame, aborted by reset at beat 30
      drive_frame(-1, -1, 30, got, ab);
      chk("abort_by_reset", ab, 1);
      chk("chain_first_read", first_iss_cyc - t_c, 1);
      chk("chain_first_addr", log_addr[0], 0);
      check_idle_outputs("midreset");
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_read_start", read_start, 0);
         chk("idle_out_valid", out_valid, 0);
         chk("idle_busy", busy, 0);
      end

      // fresh frame replays from address 0
      start = 1'b1; t_d = cyc;
      drive_frame(-1, -1, -1, got, ab);
      if (got) check_frame(t_d, NB - 1);

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cnn2_window_reader.md
Name: cnn2_window_reader

Overview:
- Read-side sequencer for the 4-channel conv1→conv2 feature-map buffer.
- Walks every KxK window of the stored conv1 map in raster order and drives the buffer read enable and read address.
- Accounts for the buffer's 1-cycle read latency and streams the 4 channel pixels, with kernel-position tags, to the conv2 MAC array over a valid/ready handshake.
- Sits between the buffer read port and the conv2 datapath.

Parameters:
- FMAP_W, 26, stored map width in pixels; pixel (y,x) is at buffer address y*FMAP_W+x.
- FMAP_H, 26, stored map height.
- K, 3, kernel size; output map is (FMAP_W-K+1) x (FMAP_H-K+1).
- ADDR_W, 16, buffer read address width.
- DATA_W, 8, pixel width per channel.

Ports:
- clk  in  1  system clock, rising edge.
- global_rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin reading one frame.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- read_start  out  1  buffer read-port enable.
- readaddr  out  ADDR_W  buffer read address.
- data_inm1..data_inm4  in  DATA_W each  buffer outputs; valid the cycle after read_start; held while read_start is low.
- data_out1..data_out4  out  DATA_W each  window pixels, passed straight through from data_inm1..4.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat.
- k_idx  out  4  kernel position kr*K+kc of the current beat.
- win_first  out  1  beat is kernel position 0.
- win_last  out  1  beat is kernel position K*K-1.

Behaviour:
- Reset: state IDLE; all counters 0; busy, done, read_start, out_valid, win_first and win_last 0; readaddr 0; k_idx 0.
- IDLE: read_start=0. On start, go to RUN and clear the counters r, c, kr, kc.
- RUN:
  - issue = !out_valid || out_ready. read_start = issue.
  - readaddr = (r+kr)*FMAP_W + (c+kc), combinational from the counters. The implementation may use an incremental row-base register instead of a multiplier; the value is identical.
  - On issue, advance the counters in order kc → kr → c → r, each wrapping at K-1, K-1, OW-1 and OH-1 respectively.
  - Issuing r=OH-1, c=OW-1, kr=kc=K-1 moves the state to DRAIN.
- Output register, on each clock edge:
  - if issue: out_valid←1, and k_idx, win_first and win_last take the tags of the address just issued;
  - else if out_ready: out_valid←0;
  - else: hold.
- Stall behaviour: data_out equals the buffer output, which is stable because read_start is low during a stall. No beat is lost or duplicated.
- DRAIN: no issue. When out_valid && out_ready on the last beat, done=1 for one cycle; the next state is IDLE.
- busy = 1 in RUN and DRAIN only.
- Latency and throughput:
  - start at cycle t → first read_start/readaddr 0 at t+1 → first out_valid at t+2.
  - With out_ready held high, one beat per cycle.
  - A frame is OW*OH*K*K beats.
- start while busy is ignored. start in the done cycle is accepted.
- global_rst mid-frame aborts to IDLE in one cycle with reset output values; the consumer discards any partial window.
- Address width: compute in ADDR_W bits. FMAP_W*FMAP_H must not exceed 2^ADDR_W; this is checked by an elaboration assertion.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W, FMAP_W, FMAP_H, K and derived OW/OH;
  - the NCH=4 channel count;
  - the reader state enum {IDLE, RUN, DRAIN}.
- One natural sub-module, cnn2_win_addr_gen: the four nested counters, the row-base and address computation, and the last-issue flag, advanced by issue.
- The top module holds the FSM, the handshake register and the tags.

Test Plan:
- Reset: assert global_rst for 2 cycles mid-activity → next cycle all outputs 0 and busy=0.
- Full frame, FMAP_W=FMAP_H=5, K=3, out_ready=1:
  - start → first 9 readaddr values are 0,1,2,5,6,7,10,11,12; the second window starts at 1.
  - The last address is 24; there are 81 beats in 81 consecutive cycles.
  - done pulses in the cycle after the 81st handshake.
- Backpressure: same frame, drop out_ready for 3 cycles at beat 20 → readaddr and data_out1..4 stay frozen and read_start=0. The beat sequence is identical to the unstalled run.
- Channel integrity: preload channel n at address a with value (n<<6)|a → every beat shows data_outn = (n<<6)|expected address, with k_idx cycling 0..8 and win_first/win_last on k_idx 0/8.
- Start handling: pulse start at beat 40 → ignored, 81 beats total. A start coincident with done begins a second frame whose first address is 0.
- Reset mid-frame at beat 30 → IDLE. A new start replays from address 0 with 81 beats.
